// File: rtl/dma_copy_engine.sv
// dma_copy_engine
// Memory-to-memory copy master. Moves i_num_beats 32-bit words from i_src_addr
// to i_dst_addr. Data is staged through a BUF_DEPTH-word buffer, so each chunk
// is one read burst followed by one write burst. Read and write phases never
// overlap.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-low reset
//   i_start                      launch pulse, accepted only when idle
//   i_src_addr/i_dst_addr        word-aligned byte addresses, latched on start
//   i_num_beats                  words to copy (0 completes with no traffic)
//   o_busy, o_done               activity flag, one-cycle completion pulse
//   o_read_request_*, o_read_len, o_read_size     read burst request channel
//   i_read_data*, o_read_data_ready               read data channel
//   o_write_request_*, o_write_len, o_write_size  write burst request channel
//   o_write_data*, i_write_data_ready             write data channel
//
// state      | meaning
// S_IDLE     | waiting for i_start
// S_RD_REQ   | read burst request for the current chunk is presented
// S_RD_DATA  | collecting chunk beats into the buffer
// S_WR_REQ   | write burst request for the current chunk is presented
// S_WR_DATA  | draining the buffer to the write data channel
// S_DONE     | raises o_done for one cycle, then back to idle
module dma_copy_engine #(
    parameter int AXI_AWIDTH = 32,
    parameter int AXI_DWIDTH = 32,
    parameter int BUF_DEPTH  = 16,
    parameter int BUF_AWIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [AXI_AWIDTH-1:0] i_src_addr,
    input  logic [AXI_AWIDTH-1:0] i_dst_addr,
    input  logic [31:0]           i_num_beats,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_read_request_valid,
    input  logic                  i_read_request_ready,
    output logic [AXI_AWIDTH-1:0] o_read_request_addr,
    output logic [31:0]           o_read_len,
    output logic [2:0]            o_read_size,
    input  logic [AXI_DWIDTH-1:0] i_read_data,
    input  logic                  i_read_data_valid,
    output logic                  o_read_data_ready,
    output logic                  o_write_request_valid,
    input  logic                  i_write_request_ready,
    output logic [AXI_AWIDTH-1:0] o_write_request_addr,
    output logic [31:0]           o_write_len,
    output logic [2:0]            o_write_size,
    output logic [AXI_DWIDTH-1:0] o_write_data,
    output logic                  o_write_data_valid,
    input  logic                  i_write_data_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_DATA,
        S_WR_REQ,
        S_WR_DATA,
        S_DONE
    } state_t;

    localparam logic [BUF_AWIDTH:0] DEPTH_C = (BUF_AWIDTH + 1)'(BUF_DEPTH);
    localparam logic [BUF_AWIDTH:0] ONE_C   = (BUF_AWIDTH + 1)'(1);

    function automatic logic [BUF_AWIDTH:0] f_chunk(input logic [31:0] rem);
        return (rem >= 32'(BUF_DEPTH)) ? DEPTH_C : rem[BUF_AWIDTH:0];
    endfunction

    state_t                r_state;
    logic [AXI_AWIDTH-1:0] r_cur_src;
    logic [AXI_AWIDTH-1:0] r_cur_dst;
    logic [31:0]           r_rem;
    logic [BUF_AWIDTH:0]   r_chunk;
    logic [BUF_AWIDTH:0]   r_len_m1;
    logic [BUF_AWIDTH:0]   r_cnt;
    logic [BUF_AWIDTH-1:0] r_wptr;
    logic [BUF_AWIDTH-1:0] r_rptr;
    logic [AXI_DWIDTH-1:0] r_buf [BUF_DEPTH];
    logic                  r_rd_req_valid;
    logic                  r_rd_data_ready;
    logic                  r_wr_req_valid;
    logic                  r_wr_data_valid;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_rd_fire;
    logic                  w_wr_fire;
    logic [BUF_AWIDTH:0]   w_cnt_inc;
    logic                  w_last_beat;
    logic [BUF_AWIDTH:0]   w_first_chunk;
    logic [31:0]           w_rem_after;
    logic [BUF_AWIDTH:0]   w_next_chunk;
    logic [AXI_AWIDTH-1:0] w_chunk_bytes;

    // The ready/valid registers are only ever set in their own data state,
    // so stray beats outside those states never fire.
    assign w_rd_fire     = r_rd_data_ready & i_read_data_valid;
    assign w_wr_fire     = r_wr_data_valid & i_write_data_ready;
    assign w_cnt_inc     = r_cnt + ONE_C;
    assign w_last_beat   = (w_cnt_inc == r_chunk);
    assign w_first_chunk = f_chunk(i_num_beats);
    assign w_rem_after   = r_rem - 32'(r_chunk);
    assign w_next_chunk  = f_chunk(w_rem_after);
    assign w_chunk_bytes = AXI_AWIDTH'({r_chunk, 2'b00});

    // Chunk size is registered as RD_REQ is entered so the very first
    // request cycle already carries the correct length.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state         <= S_IDLE;
            r_cur_src       <= '0;
            r_cur_dst       <= '0;
            r_rem           <= '0;
            r_chunk         <= '0;
            r_len_m1        <= '0;
            r_cnt           <= '0;
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_rd_req_valid  <= 1'b0;
            r_rd_data_ready <= 1'b0;
            r_wr_req_valid  <= 1'b0;
            r_wr_data_valid <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_num_beats != 32'd0) begin
                            r_cur_src      <= i_src_addr;
                            r_cur_dst      <= i_dst_addr;
                            r_rem          <= i_num_beats;
                            r_chunk        <= w_first_chunk;
                            r_len_m1       <= w_first_chunk - ONE_C;
                            r_rd_req_valid <= 1'b1;
                            r_busy         <= 1'b1;
                            r_state        <= S_RD_REQ;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (i_read_request_ready) begin
                        r_rd_req_valid  <= 1'b0;
                        r_wptr          <= '0;
                        r_cnt           <= '0;
                        r_rd_data_ready <= 1'b1;
                        r_state         <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (w_rd_fire) begin
                        r_wptr <= r_wptr + 1'b1;
                        r_cnt  <= w_cnt_inc;
                        if (w_last_beat) begin
                            r_rd_data_ready <= 1'b0;
                            r_wr_req_valid  <= 1'b1;
                            r_state         <= S_WR_REQ;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (i_write_request_ready) begin
                        r_wr_req_valid  <= 1'b0;
                        r_rptr          <= '0;
                        r_cnt           <= '0;
                        r_wr_data_valid <= 1'b1;
                        r_state         <= S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (w_wr_fire) begin
                        r_rptr <= r_rptr + 1'b1;
                        r_cnt  <= w_cnt_inc;
                        if (w_last_beat) begin
                            r_wr_data_valid <= 1'b0;
                            r_cur_src       <= r_cur_src + w_chunk_bytes;
                            r_cur_dst       <= r_cur_dst + w_chunk_bytes;
                            r_rem           <= w_rem_after;
                            if (w_rem_after != 32'd0) begin
                                r_chunk        <= w_next_chunk;
                                r_len_m1       <= w_next_chunk - ONE_C;
                                r_rd_req_valid <= 1'b1;
                                r_state        <= S_RD_REQ;
                            end else begin
                                r_busy  <= 1'b0;
                                r_state <= S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Buffer contents are don't-care after reset, so the array has no reset.
    always_ff @(posedge i_clk) begin
        if (w_rd_fire) begin
            r_buf[r_wptr] <= i_read_data;
        end
    end

    assign o_busy                = r_busy;
    assign o_done                = r_done;
    assign o_read_request_valid  = r_rd_req_valid;
    assign o_read_request_addr   = r_cur_src;
    assign o_read_len            = 32'(r_len_m1);
    assign o_read_size           = 3'd2;
    assign o_read_data_ready     = r_rd_data_ready;
    assign o_write_request_valid = r_wr_req_valid;
    assign o_write_request_addr  = r_cur_dst;
    assign o_write_len           = 32'(r_len_m1);
    assign o_write_size          = 3'd2;
    assign o_write_data_valid    = r_wr_data_valid;
    assign o_write_data          = r_wr_data_valid ? r_buf[r_rptr] : '0;

endmodule

// File: tb/tb_dma_copy_engine.sv
module tb_dma_copy_engine;
    localparam int DEPTH  = 16;
    localparam int BUDGET = 5000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] src_addr, dst_addr, num_beats;
    logic        busy, done;
    logic        rreq_valid, rreq_ready;
    logic [31:0] rreq_addr, rlen;
    logic [2:0]  rsize, wsize;
    logic [31:0] rdata;
    logic        rdata_valid, rdata_ready;
    logic        wreq_valid, wreq_ready;
    logic [31:0] wreq_addr, wlen;
    logic [31:0] wdata;
    logic        wdata_valid, wdata_ready;

    always #5 clk = ~clk;

    dma_copy_engine #(.AXI_AWIDTH(32), .AXI_DWIDTH(32), .BUF_DEPTH(DEPTH), .BUF_AWIDTH(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_src_addr(src_addr), .i_dst_addr(dst_addr), .i_num_beats(num_beats),
        .o_busy(busy), .o_done(done),
        .o_read_request_valid(rreq_valid), .i_read_request_ready(rreq_ready),
        .o_read_request_addr(rreq_addr), .o_read_len(rlen), .o_read_size(rsize),
        .i_read_data(rdata), .i_read_data_valid(rdata_valid), .o_read_data_ready(rdata_ready),
        .o_write_request_valid(wreq_valid), .i_write_request_ready(wreq_ready),
        .o_write_request_addr(wreq_addr), .o_write_len(wlen), .o_write_size(wsize),
        .o_write_data(wdata), .o_write_data_valid(wdata_valid), .i_write_data_ready(wdata_ready)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] len;
    } req_t;

    int n_checks = 0;
    int n_errors = 0;
    int cfg_bp = 0;
    int cfg_rreq_delay = 0;

    // Memory model: source words written by the stimulus, destination words by the write channel.
    logic [31:0] src_mem [logic [31:0]];
    logic [31:0] wr_mem [logic [31:0]];
    req_t rd_log[$], wr_log[$], exp_rd[$], exp_wr[$];

    int done_cnt = 0, busy_cyc = 0, act_cyc = 0, viol = 0;
    logic [31:0] m_rd_addr, m_wr_addr;
    int m_rd_left = 0, m_wr_left = 0;
    bit p_rq = 0, p_wq = 0, p_wd = 0;
    logic [31:0] p_rq_addr, p_rq_len, p_wq_addr, p_wq_len, p_wd_data;
    int rreq_wait = 0;

    function automatic logic [31:0] src_rd(input logic [31:0] a);
        return src_mem.exists(a) ? src_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] dst_rd(input logic [31:0] a);
        return wr_mem.exists(a) ? wr_mem[a] : 32'hxxxx_xxxx;
    endfunction

    // Observes handshakes with pre-edge values and keeps protocol/stability statistics.
    always @(posedge clk) begin
        if (!rst) begin
            m_rd_left = 0;
            m_wr_left = 0;
            p_rq = 0; p_wq = 0; p_wd = 0;
        end else begin
            if (p_rq && !(rreq_valid && rreq_addr == p_rq_addr && rlen == p_rq_len)) viol++;
            if (p_wq && !(wreq_valid && wreq_addr == p_wq_addr && wlen == p_wq_len)) viol++;
            if (p_wd && !(wdata_valid && wdata == p_wd_data)) viol++;
            if (done) done_cnt++;
            if (busy) busy_cyc++;
            if (rreq_valid || wreq_valid || rdata_ready || wdata_valid) act_cyc++;
            if (rreq_valid && rreq_ready) begin
                rd_log.push_back({rreq_addr, rlen});
                m_rd_addr = rreq_addr;
                m_rd_left = int'(rlen) + 1;
            end
            if (rdata_valid && rdata_ready) begin
                if (m_rd_left <= 0) viol++;
                m_rd_left--;
                m_rd_addr += 32'd4;
            end
            if (wreq_valid && wreq_ready) begin
                wr_log.push_back({wreq_addr, wlen});
                m_wr_addr = wreq_addr;
                m_wr_left = int'(wlen) + 1;
            end
            if (wdata_valid && wdata_ready) begin
                if (m_wr_left <= 0) viol++;
                wr_mem[m_wr_addr] = wdata;
                m_wr_left--;
                m_wr_addr += 32'd4;
            end
            p_rq = rreq_valid && !rreq_ready;  p_rq_addr = rreq_addr; p_rq_len = rlen;
            p_wq = wreq_valid && !wreq_ready;  p_wq_addr = wreq_addr; p_wq_len = wlen;
            p_wd = wdata_valid && !wdata_ready; p_wd_data = wdata;
        end
    end

    // Memory-side responder, driven away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            rreq_ready = 0; rdata_valid = 0; rdata = 0; wreq_ready = 0; wdata_ready = 0;
            rreq_wait = 0;
        end else begin
            if (rreq_valid) begin
                rreq_wait++;
                rreq_ready = (rreq_wait > cfg_rreq_delay);
            end else begin
                rreq_wait = 0;
                rreq_ready = 0;
            end
            wreq_ready = (cfg_bp == 0) || ($urandom_range(0, 99) >= 30);
            if (m_rd_left > 0) begin
                rdata_valid = (cfg_bp == 0) || ($urandom_range(0, 99) >= cfg_bp);
                rdata = src_rd(m_rd_addr);
            end else begin
                rdata_valid = (cfg_bp > 0) && ($urandom_range(0, 1) == 1);
                rdata = 32'hDEAD_BEEF;
            end
            wdata_ready = (cfg_bp == 0) || ($urandom_range(0, 99) >= cfg_bp);
        end
    end

    // Expected burst list derived directly from the chunking rule.
    function automatic void build_exp(input logic [31:0] s, input logic [31:0] d, input int n);
        int rem, c;
        exp_rd.delete();
        exp_wr.delete();
        rem = n;
        while (rem > 0) begin
            c = (rem > DEPTH) ? DEPTH : rem;
            exp_rd.push_back({s, 32'(c - 1)});
            exp_wr.push_back({d, 32'(c - 1)});
            s += 32'(4 * c);
            d += 32'(4 * c);
            rem -= c;
        end
    endfunction

    function automatic void fill_src(input logic [31:0] s, input int n);
        for (int i = 0; i < n; i++) src_mem[s + 32'(4 * i)] = $urandom;
    endfunction

    task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
        @(negedge clk);
        src_addr = s; dst_addr = d; num_beats = n; start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 0; start = 0; src_addr = 0; dst_addr = 0; num_beats = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, rreq_valid, rdata_ready, wreq_valid, wdata_valid} !== 6'b0)
            begin n_errors++; $display("FAIL reset_ctrl: got %b expected 000000",
                {busy, done, rreq_valid, rdata_ready, wreq_valid, wdata_valid}); end
        n_checks++;
        if ({rreq_addr, rlen, wreq_addr, wlen} !== 128'b0)
            begin n_errors++; $display("FAIL reset_addr_len: got %h expected 0", {rreq_addr, rlen, wreq_addr, wlen}); end
        n_checks++;
        if ({rsize, wsize} !== 6'b010_010)
            begin n_errors++; $display("FAIL reset_size: got %b expected 010010", {rsize, wsize}); end
        rst = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int rb, wb, db, cyc;
        cfg_bp = 0; cfg_rreq_delay = 0;
        for (int i = 0; i < 4; i++) src_mem[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
        build_exp(32'h100, 32'h400, 4);
        rb = rd_log.size(); wb = wr_log.size(); db = done_cnt;
        launch(32'h100, 32'h400, 32'd4);
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL single_busy: got %b expected 1", busy); end
        wait_done(cyc);
        n_checks++;
        if (cyc >= BUDGET) begin n_errors++; $display("FAIL single_timeout: waited %0d cycles, limit %0d", cyc, BUDGET); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (rd_log.size() - rb != 1 || wr_log.size() - wb != 1)
            begin n_errors++; $display("FAIL single_req_count: got rd=%0d wr=%0d expected 1 1", rd_log.size() - rb, wr_log.size() - wb); end
        n_checks++;
        if (rd_log[rb] !== exp_rd[0]) begin n_errors++; $display("FAIL single_rd_req: got %h expected %h", rd_log[rb], exp_rd[0]); end
        n_checks++;
        if (wr_log[wb] !== exp_wr[0]) begin n_errors++; $display("FAIL single_wr_req: got %h expected %h", wr_log[wb], exp_wr[0]); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (dst_rd(32'h400 + 32'(4 * i)) !== 32'hA0 + 32'(i))
                begin n_errors++; $display("FAIL single_data[%0d]: got %h expected %h", i, dst_rd(32'h400 + 32'(4 * i)), 32'hA0 + 32'(i)); end
        end
        n_checks++;
        if (done_cnt - db != 1) begin n_errors++; $display("FAIL single_done_count: got %0d expected 1", done_cnt - db); end
    endtask

    task automatic test_multi();
        int rb, wb, cyc;
        cfg_bp = 0; cfg_rreq_delay = 0;
        fill_src(32'h1000, 37);
        build_exp(32'h1000, 32'h8000, 37);
        rb = rd_log.size(); wb = wr_log.size();
        launch(32'h1000, 32'h8000, 32'd37);
        wait_done(cyc);
        n_checks++;
        if (cyc >= BUDGET) begin n_errors++; $display("FAIL multi_timeout: waited %0d cycles, limit %0d", cyc, BUDGET); end
        repeat (2) @(negedge clk);
        n_checks++;
        if (rd_log.size() - rb != 3 || wr_log.size() - wb != 3)
            begin n_errors++; $display("FAIL multi_req_count: got rd=%0d wr=%0d expected 3 3", rd_log.size() - rb, wr_log.size() - wb); end
        for (int i = 0; i < exp_rd.size(); i++) begin
            n_checks++;
            if (rd_log[rb + i] !== exp_rd[i] || wr_log[wb + i] !== exp_wr[i])
                begin n_errors++; $display("FAIL multi_req[%0d]: got rd=%h wr=%h expected rd=%h wr=%h", i, rd_log[rb + i], wr_log[wb + i], exp_rd[i], exp_wr[i]); end
        end
        for (int i = 0; i < 37; i++) begin
            n_checks++;
            if (dst_rd(32'h8000 + 32'(4 * i)) !== src_mem[32'h1000 + 32'(4 * i)])
                begin n_errors++; $display("FAIL multi_data[%0d]: got %h expected %h", i, dst_rd(32'h8000 + 32'(4 * i)), src_mem[32'h1000 + 32'(4 * i)]); end
        end
    endtask

    task automatic test_zero();
        int rb, wb, db, bc, ac, cyc;
        rb = rd_log.size(); wb = wr_log.size(); db = done_cnt; bc = busy_cyc; ac = act_cyc;
        launch(32'h700, 32'h7000, 32'd0);
        n_checks++;
        if ({busy, done} !== 2'b00) begin n_errors++; $display("FAIL zero_first_cycle: got busy,done=%b expected 00", {busy, done}); end
        wait_done(cyc);
        n_checks++;
        if (cyc + 1 != 2) begin n_errors++; $display("FAIL zero_done_latency: got %0d cycles expected 2", cyc + 1); end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin n_errors++; $display("FAIL zero_done_width: got %b expected 0", done); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy_cyc != bc || act_cyc != ac || rd_log.size() != rb || wr_log.size() != wb)
            begin n_errors++; $display("FAIL zero_traffic: got busy=%0d act=%0d reqs=%0d expected 0 0 0", busy_cyc - bc, act_cyc - ac, rd_log.size() - rb + wr_log.size() - wb); end
        n_checks++;
        if (done_cnt - db != 1) begin n_errors++; $display("FAIL zero_done_count: got %0d expected 1", done_cnt - db); end
    endtask

    task automatic test_backpressure();
        int rb, wb, db, vb, cyc, n;
        logic [31:0] s;
        s = 32'hFFFF_FF80;
        n = $urandom_range(33, 60);
        cfg_bp = 40; cfg_rreq_delay = 5;
        fill_src(s, n);
        build_exp(s, 32'h9000, n);
        rb = rd_log.size(); wb = wr_log.size(); db = done_cnt; vb = viol;
        launch(s, 32'h9000, 32'(n));
        wait_done(cyc);
        n_checks++;
        if (cyc >= BUDGET) begin n_errors++; $display("FAIL bp_timeout: waited %0d cycles, limit %0d", cyc, BUDGET); end
        repeat (3) @(negedge clk);
        cfg_bp = 0; cfg_rreq_delay = 0;
        n_checks++;
        if (rd_log.size() - rb != exp_rd.size() || wr_log.size() - wb != exp_wr.size())
            begin n_errors++; $display("FAIL bp_req_count: got rd=%0d wr=%0d expected %0d", rd_log.size() - rb, wr_log.size() - wb, exp_rd.size()); end
        for (int i = 0; i < exp_rd.size(); i++) begin
            n_checks++;
            if (rd_log[rb + i] !== exp_rd[i] || wr_log[wb + i] !== exp_wr[i])
                begin n_errors++; $display("FAIL bp_req[%0d]: got rd=%h wr=%h expected rd=%h wr=%h", i, rd_log[rb + i], wr_log[wb + i], exp_rd[i], exp_wr[i]); end
        end
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (dst_rd(32'h9000 + 32'(4 * i)) !== src_mem[s + 32'(4 * i)])
                begin n_errors++; $display("FAIL bp_data[%0d]: got %h expected %h", i, dst_rd(32'h9000 + 32'(4 * i)), src_mem[s + 32'(4 * i)]); end
        end
        n_checks++;
        if (viol != vb) begin n_errors++; $display("FAIL bp_stability: got %0d violations expected 0", viol - vb); end
        n_checks++;
        if (done_cnt - db != 1) begin n_errors++; $display("FAIL bp_done_count: got %0d expected 1", done_cnt - db); end
    endtask

    task automatic test_start_while_busy();
        int rb, wb, db, cyc;
        cfg_bp = 0; cfg_rreq_delay = 0;
        fill_src(32'h3000, 20);
        fill_src(32'h5000, 8);
        build_exp(32'h3000, 32'hA000, 20);
        rb = rd_log.size(); wb = wr_log.size(); db = done_cnt;
        launch(32'h3000, 32'hA000, 32'd20);
        repeat (5) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL busy_midcopy: got %b expected 1", busy); end
        src_addr = 32'h5000; dst_addr = 32'hB000; num_beats = 32'd8; start = 1;
        @(negedge clk);
        start = 0;
        wait_done(cyc);
        n_checks++;
        if (cyc >= BUDGET) begin n_errors++; $display("FAIL busy_timeout: waited %0d cycles, limit %0d", cyc, BUDGET); end
        repeat (20) @(negedge clk);
        n_checks++;
        if (rd_log.size() - rb != exp_rd.size() || wr_log.size() - wb != exp_wr.size())
            begin n_errors++; $display("FAIL busy_req_count: got rd=%0d wr=%0d expected %0d", rd_log.size() - rb, wr_log.size() - wb, exp_rd.size()); end
        for (int i = 0; i < exp_rd.size(); i++) begin
            n_checks++;
            if (rd_log[rb + i] !== exp_rd[i] || wr_log[wb + i] !== exp_wr[i])
                begin n_errors++; $display("FAIL busy_req[%0d]: got rd=%h wr=%h expected rd=%h wr=%h", i, rd_log[rb + i], wr_log[wb + i], exp_rd[i], exp_wr[i]); end
        end
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (dst_rd(32'hA000 + 32'(4 * i)) !== src_mem[32'h3000 + 32'(4 * i)])
                begin n_errors++; $display("FAIL busy_data[%0d]: got %h expected %h", i, dst_rd(32'hA000 + 32'(4 * i)), src_mem[32'h3000 + 32'(4 * i)]); end
        end
        n_checks++;
        if (done_cnt - db != 1 || busy !== 1'b0)
            begin n_errors++; $display("FAIL busy_done_count: got done=%0d busy=%b expected 1 0", done_cnt - db, busy); end
    endtask

    task automatic test_reset_mid();
        int rb, wb, cyc;
        cfg_bp = 0; cfg_rreq_delay = 0;
        fill_src(32'h4000, 20);
        launch(32'h4000, 32'hC000, 32'd20);
        cyc = 0;
        while (wdata_valid !== 1'b1 && cyc < BUDGET) begin @(negedge clk); cyc++; end
        n_checks++;
        if (cyc >= BUDGET) begin n_errors++; $display("FAIL rstmid_wait_wr: waited %0d cycles, limit %0d", cyc, BUDGET); end
        rst = 0;
        @(negedge clk);
        n_checks++;
        if ({busy, done, rreq_valid, rdata_ready, wreq_valid, wdata_valid} !== 6'b0)
            begin n_errors++; $display("FAIL rstmid_ctrl: got %b expected 000000",
                {busy, done, rreq_valid, rdata_ready, wreq_valid, wdata_valid}); end
        n_checks++;
        if ({rreq_addr, rlen, wreq_addr, wlen, wdata} !== 160'b0)
            begin n_errors++; $display("FAIL rstmid_addr_len: got %h expected 0", {rreq_addr, rlen, wreq_addr, wlen, wdata}); end
        rst = 1;
        repeat (2) @(negedge clk);
        fill_src(32'h4800, 4);
        build_exp(32'h4800, 32'hD000, 4);
        rb = rd_log.size(); wb = wr_log.size();
        launch(32'h4800, 32'hD000, 32'd4);
        wait_done(cyc);
        n_checks++;
        if (cyc >= BUDGET) begin n_errors++; $display("FAIL rstmid_timeout: waited %0d cycles, limit %0d", cyc, BUDGET); end
        repeat (2) @(negedge clk);
        n_checks++;
        if (rd_log.size() - rb != 1 || rd_log[rb] !== exp_rd[0] || wr_log[wb] !== exp_wr[0])
            begin n_errors++; $display("FAIL rstmid_req: got rd=%h wr=%h expected rd=%h wr=%h", rd_log[rb], wr_log[wb], exp_rd[0], exp_wr[0]); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (dst_rd(32'hD000 + 32'(4 * i)) !== src_mem[32'h4800 + 32'(4 * i)])
                begin n_errors++; $display("FAIL rstmid_data[%0d]: got %h expected %h", i, dst_rd(32'hD000 + 32'(4 * i)), src_mem[32'h4800 + 32'(4 * i)]); end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: reached time %0t, limit 3000000", $time);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_zero();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
